// File: rtl/ram_rw_checker_pkg.sv
// Shared types and helpers for the RAM write/read checker.
package ram_rw_pkg;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam int unsigned MAX_RD_LAT = 4;

  // Test pattern: address plus seed; the caller truncates to its data width.
  function automatic logic [31:0] exp_data(input logic [31:0] addr, input logic [31:0] seed);
    return addr + seed;
  endfunction

endpackage

// File: rtl/ram_rw_checker_if.sv
// Single-port RAM bus between the checker (master) and the RAM (slave).
interface ram_rw_checker_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [DATA_W-1:0] ram_rd_data;

  modport master (output ram_en, ram_we, ram_addr, ram_wr_data, input ram_rd_data);
  modport slave  (input ram_en, ram_we, ram_addr, ram_wr_data, output ram_rd_data);
endinterface

// File: rtl/ram_rw_checker_lat_pipe.sv
// Delay line aligning {valid, expected, addr} with the RAM read latency.
module ram_rw_lat_pipe #(
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_exp,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_exp,
  output logic [ADDR_W-1:0] out_addr
);

  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] exp_q  [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        exp_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      exp_q[0]   <= in_exp;
      addr_q[0]  <= in_addr;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        exp_q[i]   <= exp_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_exp   = exp_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/ram_rw_checker.sv
// Fills a single-port RAM with a seeded pattern, reads it back and counts mismatches.
module ram_rw_checker
  import ram_rw_pkg::*;
#(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 loop_en,
  input  logic [DATA_W-1:0]    seed_init,
  ram_rw_checker_if.master     ram,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ERR_CNT_W-1:0] pass_cnt,
  output logic [ADDR_W-1:0]    first_err_addr
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] seed_q;
  logic [2:0]        drain_cnt_q;
  logic [DATA_W-1:0] exp_cur;
  logic              addr_last, drain_last;
  logic              pipe_valid, mismatch;
  logic [DATA_W-1:0] pipe_exp;
  logic [ADDR_W-1:0] pipe_addr;

  assign exp_cur    = DATA_W'(exp_data(32'(addr_q), 32'(seed_q)));
  assign addr_last  = (addr_q == '1);
  assign drain_last = (drain_cnt_q == 3'(RD_LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    done       = 1'b0;
    ram.ram_en = 1'b0;
    ram.ram_we = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = WRITE;
      end
      WRITE: begin
        ram.ram_en = 1'b1;
        ram.ram_we = 1'b1;
        if (addr_last) state_d = READ;
      end
      READ: begin
        ram.ram_en = 1'b1;
        if (addr_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_last) state_d = loop_en ? WRITE : DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram.ram_addr    = addr_q;
  assign ram.ram_wr_data = (state_q == WRITE) ? exp_cur : '0;

  ram_rw_lat_pipe #(.DEPTH(RD_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (state_q == READ),
    .in_exp    (exp_cur),
    .in_addr   (addr_q),
    .out_valid (pipe_valid),
    .out_exp   (pipe_exp),
    .out_addr  (pipe_addr)
  );

  assign mismatch = pipe_valid && (ram.ram_rd_data != pipe_exp);

  // Compare update sits after the state case so a final-cycle mismatch and pass end both land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q         <= '0;
      seed_q         <= '0;
      drain_cnt_q    <= '0;
      err            <= 1'b0;
      err_cnt        <= '0;
      pass_cnt       <= '0;
      first_err_addr <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          seed_q         <= seed_init;
          addr_q         <= '0;
          drain_cnt_q    <= '0;
          err            <= 1'b0;
          err_cnt        <= '0;
          pass_cnt       <= '0;
          first_err_addr <= '0;
        end
        WRITE, READ: addr_q <= addr_q + 1'b1;
        DRAIN: begin
          if (drain_last) begin
            drain_cnt_q <= '0;
            if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
            if (loop_en) begin
              seed_q <= seed_q + 1'b1;
              addr_q <= '0;
            end
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
      if (mismatch) begin
        err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (!err) first_err_addr <= pipe_addr;
      end
    end
  end

endmodule

// File: tb/tb_ram_rw_checker.sv
// Directed bench: three checker instances (default, RD_LAT=3, DATA_W=4) with behavioural RAMs.
module tb_ram_rw_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Instance 1: defaults
  logic        start1 = 0, loop1 = 0, busy1, done1, err1, flip1 = 0;
  logic [7:0]  seed1 = 0;
  logic [15:0] err_cnt1, pass_cnt1;
  logic [4:0]  fea1;
  ram_rw_checker_if #(.ADDR_W(5), .DATA_W(8)) bus1 ();
  ram_rw_checker #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1), .ERR_CNT_W(16)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .loop_en(loop1), .seed_init(seed1),
    .ram(bus1), .busy(busy1), .done(done1), .err(err1), .err_cnt(err_cnt1),
    .pass_cnt(pass_cnt1), .first_err_addr(fea1));

  // Instance 3: RD_LAT=3, model latency selectable
  logic        start3 = 0, busy3, done3, err3;
  logic [1:0]  lat3_idx = 2'd2;
  logic [15:0] err_cnt3, pass_cnt3;
  logic [4:0]  fea3;
  ram_rw_checker_if #(.ADDR_W(5), .DATA_W(8)) bus3 ();
  ram_rw_checker #(.ADDR_W(5), .DATA_W(8), .RD_LAT(3), .ERR_CNT_W(16)) d3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .loop_en(1'b0), .seed_init(8'h00),
    .ram(bus3), .busy(busy3), .done(done3), .err(err3), .err_cnt(err_cnt3),
    .pass_cnt(pass_cnt3), .first_err_addr(fea3));

  // Instance 4: DATA_W=4
  logic        start4 = 0, busy4, done4, err4;
  logic [15:0] err_cnt4, pass_cnt4;
  logic [4:0]  fea4;
  ram_rw_checker_if #(.ADDR_W(5), .DATA_W(4)) bus4 ();
  ram_rw_checker #(.ADDR_W(5), .DATA_W(4), .RD_LAT(1), .ERR_CNT_W(16)) d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .loop_en(1'b0), .seed_init(4'h0),
    .ram(bus4), .busy(busy4), .done(done4), .err(err4), .err_cnt(err_cnt4),
    .pass_cnt(pass_cnt4), .first_err_addr(fea4));

  // RAM models
  logic [7:0] mem1 [32];
  logic [7:0] p1;
  logic [7:0] mem3 [32];
  logic [7:0] p3 [4];
  logic [3:0] mem4 [32];
  logic [3:0] p4;

  always @(posedge clk) begin
    if (bus1.ram_en && bus1.ram_we) mem1[bus1.ram_addr] <= bus1.ram_wr_data;
    p1 <= mem1[bus1.ram_addr] ^ {7'b0, flip1 && bus1.ram_en && !bus1.ram_we &&
                                       (bus1.ram_addr == 5'd7 || bus1.ram_addr == 5'd20)};
    if (bus3.ram_en && bus3.ram_we) mem3[bus3.ram_addr] <= bus3.ram_wr_data;
    p3[0] <= mem3[bus3.ram_addr];
    for (int i = 1; i < 4; i++) p3[i] <= p3[i-1];
    if (bus4.ram_en && bus4.ram_we) mem4[bus4.ram_addr] <= bus4.ram_wr_data;
    p4 <= mem4[bus4.ram_addr];
  end
  assign bus1.ram_rd_data = p1;
  assign bus3.ram_rd_data = p3[lat3_idx];
  assign bus4.ram_rd_data = p4;

  // Monitors
  logic [7:0] wlog1 [$];
  logic [3:0] wlog4 [$];
  int dpulse1 = 0;
  int rcnt1 = 0;
  always @(negedge clk) begin
    if (bus1.ram_en && bus1.ram_we) wlog1.push_back(bus1.ram_wr_data);
    if (bus1.ram_en && !bus1.ram_we) rcnt1++;
    if (done1) dpulse1++;
    if (bus4.ram_en && bus4.ram_we) wlog4.push_back(bus4.ram_wr_data);
  end

  // Start pulse on edge 0; returns the cycle index in which done is seen, -1 on timeout.
  task automatic run(input int which, input int poke, output int cyc);
    logic d;
    @(negedge clk);
    case (which)
      1: start1 = 1;
      3: start3 = 1;
      default: start4 = 1;
    endcase
    @(posedge clk);
    cyc = 0;
    d = 0;
    while (!d && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin start1 = 0; start3 = 0; start4 = 0; end
      if (poke != 0 && cyc == poke) start1 = 1;
      if (poke != 0 && cyc == poke + 1) start1 = 0;
      case (which)
        1: d = done1;
        3: d = done3;
        default: d = done4;
      endcase
    end
    if (!d) cyc = -1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({busy1, done1, err1} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy1, done1, err1}); else passes++;
    checks++; if ({err_cnt1, pass_cnt1, fea1} !== 37'd0) $display("FAIL reset_counters: got %h want 0", {err_cnt1, pass_cnt1, fea1}); else passes++;
    checks++; if ({bus1.ram_en, bus1.ram_we, bus1.ram_addr, bus1.ram_wr_data} !== 15'd0)
      $display("FAIL reset_ram_bus: got %h want 0", {bus1.ram_en, bus1.ram_we, bus1.ram_addr, bus1.ram_wr_data}); else passes++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({busy1, busy3, busy4} !== 3'b000) $display("FAIL idle_busy: got %b want 000", {busy1, busy3, busy4}); else passes++;
  endtask

  task automatic test_basic();
    int cyc, base, bad, r0;
    base = wlog1.size();
    r0 = rcnt1;
    run(1, 0, cyc);
    checks++; if (cyc !== 66) $display("FAIL basic_done_cycle: got %0d want 66", cyc); else passes++;
    bad = 0;
    if (wlog1.size() != base + 32) bad = 99;
    else for (int i = 0; i < 32; i++) if (wlog1[base+i] !== 8'(i)) bad++;
    checks++; if (bad !== 0) $display("FAIL basic_write_data: got %0d bad words want 0", bad); else passes++;
    checks++; if (rcnt1 - r0 !== 32) $display("FAIL basic_read_count: got %0d want 32", rcnt1 - r0); else passes++;
    checks++; if ({err1, err_cnt1} !== 17'd0) $display("FAIL basic_err: got %0d/%0d want 0/0", err1, err_cnt1); else passes++;
    checks++; if (pass_cnt1 !== 16'd1) $display("FAIL basic_pass_cnt: got %0d want 1", pass_cnt1); else passes++;
  endtask

  task automatic test_errors();
    int cyc;
    flip1 = 1;
    run(1, 0, cyc);
    checks++; if (cyc !== 66) $display("FAIL err_done_cycle: got %0d want 66", cyc); else passes++;
    checks++; if (err1 !== 1'b1) $display("FAIL err_flag: got %0d want 1", err1); else passes++;
    checks++; if (err_cnt1 !== 16'd2) $display("FAIL err_cnt: got %0d want 2", err_cnt1); else passes++;
    checks++; if (fea1 !== 5'd7) $display("FAIL first_err_addr: got %0d want 7", fea1); else passes++;
    repeat (5) @(negedge clk);
    checks++; if ({err1, err_cnt1, fea1} !== {1'b1, 16'd2, 5'd7})
      $display("FAIL err_persist_idle: got %0d/%0d/%0d want 1/2/7", err1, err_cnt1, fea1); else passes++;
    flip1 = 0;
  endtask

  task automatic test_start_busy();
    int cyc;
    run(1, 20, cyc);
    checks++; if (cyc !== 66) $display("FAIL busy_start_timing: got %0d want 66", cyc); else passes++;
    checks++; if ({err1, pass_cnt1} !== {1'b0, 16'd1}) $display("FAIL busy_start_state: got err=%0d pass=%0d want 0/1", err1, pass_cnt1); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (busy1 !== 1'b0) $display("FAIL busy_start_idle: got %0d want 0", busy1); else passes++;
  endtask

  task automatic test_loop();
    int cyc, pc1, pc2, pc3, base, bad, dp0;
    base = wlog1.size();
    dp0 = dpulse1;
    seed1 = 8'hF0;
    loop1 = 1;
    pc1 = 0; pc2 = 0; pc3 = 0;
    @(negedge clk);
    start1 = 1;
    @(posedge clk);
    cyc = 0;
    while (pc3 == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start1 = 0;
      if (pass_cnt1 == 16'd1 && pc1 == 0) pc1 = cyc;
      if (pass_cnt1 == 16'd2 && pc2 == 0) pc2 = cyc;
      if (pass_cnt1 == 16'd3 && pc3 == 0) pc3 = cyc;
    end
    loop1 = 0;
    while (!done1 && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if ({pc1, pc2, pc3} !== {32'd66, 32'd131, 32'd196})
      $display("FAIL loop_pass_timing: got %0d,%0d,%0d want 66,131,196", pc1, pc2, pc3); else passes++;
    checks++; if (cyc !== 261) $display("FAIL loop_done_cycle: got %0d want 261", cyc); else passes++;
    checks++; if (pass_cnt1 !== 16'd4) $display("FAIL loop_pass_cnt: got %0d want 4", pass_cnt1); else passes++;
    bad = 0;
    if (wlog1.size() != base + 128) bad = 999;
    else for (int i = 0; i < 32; i++) begin
      if (wlog1[base+i] !== 8'(8'hF0 + i)) bad++;
      if (wlog1[base+32+i] !== 8'(8'hF1 + i)) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL loop_write_data: got %0d bad words want 0", bad); else passes++;
    @(negedge clk);
    checks++; if (dpulse1 - dp0 !== 1) $display("FAIL loop_done_pulses: got %0d want 1", dpulse1 - dp0); else passes++;
    checks++; if (err1 !== 1'b0) $display("FAIL loop_err: got %0d want 0", err1); else passes++;
    seed1 = 8'h00;
  endtask

  task automatic test_latency();
    int cyc;
    lat3_idx = 2'd2;
    run(3, 0, cyc);
    checks++; if (cyc !== 68) $display("FAIL lat3_done_cycle: got %0d want 68", cyc); else passes++;
    checks++; if ({err3, err_cnt3} !== 17'd0) $display("FAIL lat3_err: got %0d/%0d want 0/0", err3, err_cnt3); else passes++;
    lat3_idx = 2'd1;
    run(3, 0, cyc);
    checks++; if (cyc !== 68) $display("FAIL lat2_done_cycle: got %0d want 68", cyc); else passes++;
    checks++; if (err3 !== 1'b1 || err_cnt3 == 16'd0) $display("FAIL lat2_err: got %0d/%0d want 1/nonzero", err3, err_cnt3); else passes++;
    checks++; if (fea3 !== 5'd0) $display("FAIL lat2_first_err_addr: got %0d want 0", fea3); else passes++;
    lat3_idx = 2'd2;
  endtask

  task automatic test_narrow();
    int cyc, base, bad;
    base = wlog4.size();
    run(4, 0, cyc);
    checks++; if (cyc !== 66) $display("FAIL narrow_done_cycle: got %0d want 66", cyc); else passes++;
    bad = 0;
    if (wlog4.size() != base + 32) bad = 99;
    else for (int i = 0; i < 32; i++) if (wlog4[base+i] !== 4'(i % 16)) bad++;
    checks++; if (bad !== 0) $display("FAIL narrow_write_data: got %0d bad words want 0", bad); else passes++;
    checks++; if ({err4, err_cnt4, pass_cnt4} !== {1'b0, 16'd0, 16'd1})
      $display("FAIL narrow_status: got %0d/%0d/%0d want 0/0/1", err4, err_cnt4, pass_cnt4); else passes++;
  endtask

  task automatic test_reset_mid();
    int cyc, dp0;
    dp0 = dpulse1;
    @(negedge clk);
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    cyc = 0;
    while (!(bus1.ram_we && bus1.ram_addr == 5'd10) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (!(bus1.ram_we && bus1.ram_addr == 5'd10)) $display("FAIL rst_mid_reach_addr10: got addr %0d we %0d want 10/1", bus1.ram_addr, bus1.ram_we); else passes++;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({busy1, done1, err1, err_cnt1, pass_cnt1, fea1} !== 40'd0)
      $display("FAIL rst_mid_status: got %h want 0", {busy1, done1, err1, err_cnt1, pass_cnt1, fea1}); else passes++;
    checks++; if ({bus1.ram_en, bus1.ram_we, bus1.ram_addr, bus1.ram_wr_data} !== 15'd0)
      $display("FAIL rst_mid_ram_bus: got %h want 0", {bus1.ram_en, bus1.ram_we, bus1.ram_addr, bus1.ram_wr_data}); else passes++;
    checks++; if ({err3, err_cnt3} !== 17'd0) $display("FAIL rst_mid_other_inst: got %0d/%0d want 0/0", err3, err_cnt3); else passes++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    checks++; if (dpulse1 - dp0 !== 0) $display("FAIL rst_mid_no_done: got %0d pulses want 0", dpulse1 - dp0); else passes++;
    checks++; if (busy1 !== 1'b0) $display("FAIL rst_mid_idle: got busy %0d want 0", busy1); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_start_busy();
    test_loop();
    test_latency();
    test_narrow();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
